cmd_decode_frame: RTL and testbench

Parametrised successor to the UART command decoder. It parses the received byte stream into write frames (command byte, optional length byte, payload) and read commands. Payload bytes go to the SDRAM write FIFO. A write trigger with the frame length, or a read trigger, goes to the SDRAM read/write arbiter. The block adds a variable-length mode, an inter-byte timeout, FIFO-full protection and error reporting.

---
 rtl/sdram_cmd_pkg.sv | 20 ++
 rtl/frame_timeout_cnt.sv | 41 ++++
 rtl/cmd_decode_frame.sv | 171 +++++++++++++++++
 tb/tb_cmd_decode_frame.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_cmd_pkg.sv
// Shared definitions for the UART command decoder: parser states, default
// command bytes and the width helper for length counters.
package sdram_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [7:0] DEF_WR_CMD = 8'h55;
  localparam logic [7:0] DEF_RD_CMD = 8'hAA;

  // Bits needed to hold any count 0..max_len.
  function automatic int len_width(input int max_len);
    return (max_len < 1) ? 1 : $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// Idle-cycle counter for an open frame: counts while enabled, restarts on
// clear, and flags the cycle in which the TIMEOUT_CYC-th idle cycle ends.
module frame_timeout_cnt #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // expired is combinational so the parser can register its error pulse
  // in the same edge that leaves the frame.
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (!en || clr) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
      expired = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_decode_frame.sv
// UART byte-stream parser: write frames go to the SDRAM write FIFO with a
// completion trigger, read commands raise a read trigger.
module cmd_decode_frame
  import sdram_cmd_pkg::*;
#(
  parameter logic [7:0] WR_CMD      = DEF_WR_CMD,
  parameter logic [7:0] RD_CMD      = DEF_RD_CMD,
  parameter int         VAR_LEN     = 0,
  parameter int         FIX_LEN     = 4,
  parameter int         MAX_LEN     = 255,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         LEN_W       = len_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_flag,
  input  logic [7:0]       uart_data,
  input  logic             wfifo_full,
  output logic             wfifo_wr_en,
  output logic [7:0]       wfifo_data,
  output logic             wr_trig,
  output logic [LEN_W-1:0] wr_len,
  output logic             rd_trig,
  output logic             busy,
  output logic             err_len,
  output logic             err_timeout,
  output logic             err_ovf
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wr_trig_q, wr_trig_d;
  logic [LEN_W-1:0] wr_len_q, wr_len_d;
  logic             rd_trig_q, rd_trig_d;
  logic             busy_q, busy_d;
  logic             err_len_q, err_len_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_ovf_q, err_ovf_d;

  logic tmr_en;
  logic tmo_expired;

  assign tmr_en = (state_q == ST_LEN) || (state_q == ST_PAYLOAD);

  frame_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .en      (tmr_en),
    .clr     (uart_flag),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wdata_d   = wdata_q;
    wr_trig_d = 1'b0;
    wr_len_d  = wr_len_q;
    rd_trig_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovf_d = 1'b0;

    case (state_q)
      ST_LEN: begin
        if (tmo_expired) begin
          err_tmo_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (uart_flag) begin
          if (uart_data == 8'd0 || int'(uart_data) > MAX_LEN) begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            rem_d   = LEN_W'(uart_data);
            len_d   = LEN_W'(uart_data);
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (tmo_expired) begin
          err_tmo_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (uart_flag) begin
          if (wfifo_full) begin
            err_ovf_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            wr_en_d = 1'b1;
            wdata_d = uart_data;
            rem_d   = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        wr_trig_d = 1'b1;
        wr_len_d  = len_q;
        state_d   = ST_IDLE;
      end
      default: ;
    endcase

    // DONE accepts a new command byte exactly like IDLE so none is lost.
    if ((state_q == ST_IDLE || state_q == ST_DONE) && uart_flag) begin
      if (uart_data == WR_CMD) begin
        if (VAR_LEN != 0) begin
          state_d = ST_LEN;
        end else begin
          rem_d   = LEN_W'(FIX_LEN);
          len_d   = LEN_W'(FIX_LEN);
          state_d = ST_PAYLOAD;
        end
      end else if (uart_data == RD_CMD) begin
        rd_trig_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      wdata_q   <= '0;
      wr_trig_q <= 1'b0;
      wr_len_q  <= '0;
      rd_trig_q <= 1'b0;
      busy_q    <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wdata_q   <= wdata_d;
      wr_trig_q <= wr_trig_d;
      wr_len_q  <= wr_len_d;
      rd_trig_q <= rd_trig_d;
      busy_q    <= busy_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign wfifo_wr_en = wr_en_q;
  assign wfifo_data  = wdata_q;
  assign wr_trig     = wr_trig_q;
  assign wr_len      = wr_len_q;
  assign rd_trig     = rd_trig_q;
  assign busy        = busy_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_tmo_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_cmd_decode_frame.sv
// Bench for cmd_decode_frame: a fixed-length and a variable-length instance
// checked against a frame-level reference model of the byte protocol.
module tb_cmd_decode_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] uart_data = 8'h00;
  logic       wfifo_full = 1'b0;
  logic       flag_f = 1'b0;
  logic       flag_v = 1'b0;

  always #5 clk = ~clk;

  logic       wr_en_f, trig_f, rd_f, busy_f, el_f, et_f, eo_f;
  logic [7:0] data_f, len_f;
  logic       wr_en_v, trig_v, rd_v, busy_v, el_v, et_v, eo_v;
  logic [7:0] data_v;
  logic [3:0] len_v;

  cmd_decode_frame #(
    .VAR_LEN(0), .FIX_LEN(4), .MAX_LEN(255), .TIMEOUT_CYC(100)
  ) u_fix (
    .clk(clk), .rst(rst), .uart_flag(flag_f), .uart_data(uart_data),
    .wfifo_full(wfifo_full), .wfifo_wr_en(wr_en_f), .wfifo_data(data_f),
    .wr_trig(trig_f), .wr_len(len_f), .rd_trig(rd_f), .busy(busy_f),
    .err_len(el_f), .err_timeout(et_f), .err_ovf(eo_f)
  );

  cmd_decode_frame #(
    .VAR_LEN(1), .FIX_LEN(4), .MAX_LEN(8), .TIMEOUT_CYC(100)
  ) u_var (
    .clk(clk), .rst(rst), .uart_flag(flag_v), .uart_data(uart_data),
    .wfifo_full(wfifo_full), .wfifo_wr_en(wr_en_v), .wfifo_data(data_v),
    .wr_trig(trig_v), .wr_len(len_v), .rd_trig(rd_v), .busy(busy_v),
    .err_len(el_v), .err_timeout(et_v), .err_ovf(eo_v)
  );

  // Index 0 = fixed instance, 1 = variable instance.
  logic       m_flag[2], m_en[2], m_trig[2], m_rd[2], m_busy[2];
  logic       m_el[2], m_et[2], m_eo[2];
  logic [7:0] m_data[2], m_len[2];
  assign m_flag[0] = flag_f;  assign m_flag[1] = flag_v;
  assign m_en[0]   = wr_en_f; assign m_en[1]   = wr_en_v;
  assign m_trig[0] = trig_f;  assign m_trig[1] = trig_v;
  assign m_rd[0]   = rd_f;    assign m_rd[1]   = rd_v;
  assign m_busy[0] = busy_f;  assign m_busy[1] = busy_v;
  assign m_el[0]   = el_f;    assign m_el[1]   = el_v;
  assign m_et[0]   = et_f;    assign m_et[1]   = et_v;
  assign m_eo[0]   = eo_f;    assign m_eo[1]   = eo_v;
  assign m_data[0] = data_f;  assign m_data[1] = data_v;
  assign m_len[0]  = len_f;   assign m_len[1]  = {4'h0, len_v};

  int checks = 0;
  int errors = 0;

  // Reference model: protocol-level view of each instance.
  bit         mdl_in_frame[2];
  bit         mdl_need_len[2];
  int         mdl_left[2];
  int         mdl_flen[2];
  int         exp_rd[2], exp_el[2], exp_et[2], exp_eo[2], exp_trig[2];
  int         obs_rd[2], obs_el[2], obs_et[2], obs_eo[2], obs_trig[2];
  logic [7:0] exp_q0[$], exp_q1[$];
  logic [7:0] exp_len_q0[$], exp_len_q1[$];
  logic       prev_en[2];

  function automatic int max_len_of(input int s);
    return (s == 0) ? 255 : 8;
  endfunction

  function automatic void model_byte(input int s, input logic [7:0] d, input logic full);
    if (!mdl_in_frame[s]) begin
      if (d == 8'h55) begin
        mdl_in_frame[s] = 1'b1;
        if (s == 1) begin
          mdl_need_len[s] = 1'b1;
        end else begin
          mdl_left[s] = 4;
          mdl_flen[s] = 4;
        end
      end else if (d == 8'hAA) begin
        exp_rd[s]++;
      end
    end else if (mdl_need_len[s]) begin
      mdl_need_len[s] = 1'b0;
      if (d == 8'd0 || int'(d) > max_len_of(s)) begin
        exp_el[s]++;
        mdl_in_frame[s] = 1'b0;
      end else begin
        mdl_left[s] = int'(d);
        mdl_flen[s] = int'(d);
      end
    end else if (full) begin
      exp_eo[s]++;
      mdl_in_frame[s] = 1'b0;
    end else begin
      if (s == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
      mdl_left[s]--;
      if (mdl_left[s] == 0) begin
        if (s == 0) exp_len_q0.push_back(8'(mdl_flen[s]));
        else        exp_len_q1.push_back(8'(mdl_flen[s]));
        exp_trig[s]++;
        mdl_in_frame[s] = 1'b0;
      end
    end
  endfunction

  function automatic void model_abort(input int s, input bit timeout);
    if (timeout && mdl_in_frame[s]) exp_et[s]++;
    mdl_in_frame[s] = 1'b0;
    mdl_need_len[s] = 1'b0;
  endfunction

  function automatic bit pop_data(input int s, output logic [7:0] v);
    v = 8'h00;
    if (s == 0) begin
      if (exp_q0.size() == 0) return 1'b0;
      v = exp_q0.pop_front();
    end else begin
      if (exp_q1.size() == 0) return 1'b0;
      v = exp_q1.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic bit pop_len(input int s, output logic [7:0] v);
    v = 8'h00;
    if (s == 0) begin
      if (exp_len_q0.size() == 0) return 1'b0;
      v = exp_len_q0.pop_front();
    end else begin
      if (exp_len_q1.size() == 0) return 1'b0;
      v = exp_len_q1.pop_front();
    end
    return 1'b1;
  endfunction

  // Scoreboard: outputs sampled 1 time unit after each rising edge.
  always @(posedge clk) begin : monitor
    logic [7:0] want;
    bit         have;
    #1;
    for (int s = 0; s < 2; s++) begin
      if (!rst) begin
        if (m_en[s]) begin
          checks++;
          if (m_flag[s] !== 1'b1) begin
            errors++;
            $display("FAIL wr_en_latency inst%0d: uart_flag at edge %b, required 1", s, m_flag[s]);
          end
          have = pop_data(s, want);
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL fifo_unexpected inst%0d: got write %h, required none", s, m_data[s]);
          end else if (m_data[s] !== want) begin
            errors++;
            $display("FAIL fifo_data inst%0d: got %h, required %h", s, m_data[s], want);
          end
        end
        if (m_trig[s]) begin
          obs_trig[s]++;
          checks++;
          if (prev_en[s] !== 1'b1) begin
            errors++;
            $display("FAIL wr_trig_timing inst%0d: previous wr_en %b, required 1", s, prev_en[s]);
          end
          have = pop_len(s, want);
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL wr_trig_unexpected inst%0d: got len %0d, required no trigger", s, m_len[s]);
          end else if (m_len[s] !== want) begin
            errors++;
            $display("FAIL wr_len inst%0d: got %0d, required %0d", s, m_len[s], want);
          end
        end
        if (m_rd[s]) obs_rd[s]++;
        if (m_el[s]) obs_el[s]++;
        if (m_et[s]) obs_et[s]++;
        if (m_eo[s]) obs_eo[s]++;
      end
      prev_en[s] = m_en[s];
    end
  end

  // Driver: called at a falling edge, presents one byte for one cycle.
  task automatic send_byte(input int s, input logic [7:0] d, input logic full, input int gap);
    uart_data  = d;
    wfifo_full = full;
    if (s == 0) flag_f = 1'b1; else flag_v = 1'b1;
    model_byte(s, d, full);
    @(negedge clk);
    flag_f     = 1'b0;
    flag_v     = 1'b0;
    wfifo_full = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_end(input int s, input string tag);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_trig[s] !== exp_trig[s]) begin
      errors++;
      $display("FAIL %s_wr_trig_count inst%0d: got %0d, required %0d", tag, s, obs_trig[s], exp_trig[s]);
    end
    checks++;
    if (obs_rd[s] !== exp_rd[s]) begin
      errors++;
      $display("FAIL %s_rd_trig_count inst%0d: got %0d, required %0d", tag, s, obs_rd[s], exp_rd[s]);
    end
    checks++;
    if (obs_el[s] !== exp_el[s]) begin
      errors++;
      $display("FAIL %s_err_len_count inst%0d: got %0d, required %0d", tag, s, obs_el[s], exp_el[s]);
    end
    checks++;
    if (obs_et[s] !== exp_et[s]) begin
      errors++;
      $display("FAIL %s_err_timeout_count inst%0d: got %0d, required %0d", tag, s, obs_et[s], exp_et[s]);
    end
    checks++;
    if (obs_eo[s] !== exp_eo[s]) begin
      errors++;
      $display("FAIL %s_err_ovf_count inst%0d: got %0d, required %0d", tag, s, obs_eo[s], exp_eo[s]);
    end
    checks++;
    if (((s == 0) ? exp_q0.size() : exp_q1.size()) != 0) begin
      errors++;
      $display("FAIL %s_fifo_missing inst%0d: got %0d writes outstanding, required 0", tag, s,
               (s == 0) ? exp_q0.size() : exp_q1.size());
    end
    checks++;
    if (m_busy[s] !== mdl_in_frame[s]) begin
      errors++;
      $display("FAIL %s_busy inst%0d: got %b, required %b", tag, s, m_busy[s], mdl_in_frame[s]);
    end
  endtask

  task automatic check_all_zero(input int s, input string tag);
    logic [18:0] got;
    got = {m_en[s], m_trig[s], m_rd[s], m_busy[s], m_el[s], m_et[s], m_eo[s], m_data[s], m_len[s][3:0]};
    checks++;
    if (got !== '0 || m_len[s] !== 8'h00) begin
      errors++;
      $display("FAIL %s inst%0d: outputs {en,trig,rd,busy,el,et,eo,data,len} = %h len=%h, required all 0",
               tag, s, got, m_len[s]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero(0, "reset_state");
    check_all_zero(1, "reset_state");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_frame();
    logic [7:0] seq [6] = '{8'h55, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA};
    foreach (seq[i]) send_byte(0, seq[i], 1'b0, 19);
    check_end(0, "fixed_frame");
  endtask

  task automatic test_var_frame();
    logic [7:0] seq [5] = '{8'h55, 8'h03, 8'hAA, 8'h55, 8'h01};
    foreach (seq[i]) send_byte(1, seq[i], 1'b0, 2);
    check_end(1, "var_frame");
  endtask

  task automatic test_len_errors();
    send_byte(1, 8'h55, 1'b0, 1);
    send_byte(1, 8'h00, 1'b0, 3);
    send_byte(1, 8'h55, 1'b0, 1);
    send_byte(1, 8'h09, 1'b0, 3);
    send_byte(1, 8'h55, 1'b0, 1);
    send_byte(1, 8'h08, 1'b0, 0);
    for (int i = 0; i < 8; i++) send_byte(1, 8'($urandom_range(0, 255)), 1'b0, 0);
    check_end(1, "len_errors");
  endtask

  task automatic test_timeout();
    int found;
    send_byte(0, 8'h55, 1'b0, 2);
    send_byte(0, 8'h12, 1'b0, 0);
    model_abort(0, 1'b1);
    found = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (et_f && found == 0) found = k;
    end
    checks++;
    if (found != 100) begin
      errors++;
      $display("FAIL timeout_latency: err_timeout after %0d idle cycles (0 = never), required 100", found);
    end
    @(negedge clk);
    send_byte(0, 8'h55, 1'b0, 1);
    for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom_range(0, 255)), 1'b0, 1);
    check_end(0, "timeout");
  endtask

  task automatic test_overflow();
    send_byte(0, 8'h55, 1'b0, 1);
    send_byte(0, 8'h11, 1'b0, 1);
    send_byte(0, 8'h22, 1'b0, 1);
    send_byte(0, 8'h33, 1'b1, 1);
    send_byte(0, 8'h44, 1'b0, 1);
    check_end(0, "overflow");
  endtask

  task automatic test_reset_mid_frame();
    send_byte(0, 8'h55, 1'b0, 1);
    send_byte(0, 8'hA1, 1'b0, 1);
    send_byte(0, 8'hA2, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero(0, "reset_mid_frame");
    @(negedge clk);
    rst = 1'b0;
    model_abort(0, 1'b0);
    send_byte(0, 8'h55, 1'b0, 1);
    foreach (exp_rd[i]) ;
    send_byte(0, 8'hC1, 1'b0, 1);
    send_byte(0, 8'hAA, 1'b0, 1);
    send_byte(0, 8'h55, 1'b0, 1);
    send_byte(0, 8'hC4, 1'b0, 1);
    check_end(0, "reset_mid_frame");
  endtask

  task automatic test_back_to_back();
    send_byte(0, 8'h55, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'(8'h60 + i), 1'b0, 0);
    send_byte(0, 8'hAA, 1'b0, 0);
    send_byte(0, 8'h55, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'(8'h70 + i), 1'b0, 0);
    send_byte(0, 8'h55, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'(8'h80 + i), 1'b0, 0);
    check_end(0, "back_to_back");
  endtask

  task automatic test_random(input int s, input int n);
    logic [7:0] d;
    int         r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      d = 8'h55;
      else if (r == 3) d = 8'hAA;
      else if (r <= 6) d = 8'($urandom_range(0, 10));
      else             d = 8'($urandom_range(0, 255));
      send_byte(s, d, ($urandom_range(0, 15) == 0), $urandom_range(0, 3));
    end
    check_end(s, "random");
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fixed_frame();
    test_var_frame();
    test_len_errors();
    test_timeout();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    test_random(0, 300);
    test_random(1, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
